// File: rtl/mw_control_pkg.sv
// Shared RV32I control constants: opcodes, load/store widths and writeback
// source encodings used by every pipeline stage's control decoder.
package mw_control_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_CSR    = 7'b1110011;

    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_H = 3'b001;
    localparam logic [2:0] F3_W = 3'b010;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/mw_control.sv
// Memory/writeback stage control decoder: purely combinational decode of
// opcode/funct3 into store mask, load enable, writeback select and rf write.
module mw_control
    import mw_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [3:0] w_mask,
    output logic       re,
    output logic [1:0] wb_sel,
    output logic       rwe
);

    // Clock and reset exist only so every stage block has the same interface.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};

    always_comb begin
        w_mask = 4'b0000;
        re     = 1'b0;
        wb_sel = WB_MEM;
        rwe    = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                re  = 1'b1;
                rwe = 1'b1;
            end
            OPC_STORE: begin
                case (funct3)
                    F3_B:    w_mask = 4'b0001;
                    F3_H:    w_mask = 4'b0011;
                    F3_W:    w_mask = 4'b1111;
                    default: w_mask = 4'b0000;
                endcase
            end
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                wb_sel = WB_ALU;
                rwe    = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                wb_sel = WB_PC4;
                rwe    = 1'b1;
            end
            // Branches, csrw/csrwi with rd=x0 and unknown opcodes do nothing.
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mw_control.sv
// Scoreboard bench for mw_control: stimulus queues expected responses, a
// negedge monitor pops and compares them against the live decoder outputs.
module tb_mw_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] w_mask;
    logic       re;
    logic [1:0] wb_sel;
    logic       rwe;

    typedef struct {
        logic [7:0] resp;   // {w_mask, re, wb_sel, rwe}
        logic [6:0] op;
        logic [2:0] f3;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   txn;

    mw_control dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .funct3 (funct3),
        .w_mask (w_mask),
        .re     (re),
        .wb_sel (wb_sel),
        .rwe    (rwe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent decode table written from the instruction-set definition.
    function automatic logic [7:0] model(input logic [6:0] op, input logic [2:0] f3);
        logic [7:0] r;
        r = 8'b0000_0_00_0;
        case (op)
            7'b0000011: r = 8'b0000_1_00_1;
            7'b0100011: begin
                case (f3)
                    3'b000:  r = 8'b0001_0_00_0;
                    3'b001:  r = 8'b0011_0_00_0;
                    3'b010:  r = 8'b1111_0_00_0;
                    default: r = 8'b0000_0_00_0;
                endcase
            end
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: r = 8'b0000_0_01_1;
            7'b1101111, 7'b1100111:                         r = 8'b0000_0_10_1;
            default:                                        r = 8'b0000_0_00_0;
        endcase
        return r;
    endfunction

    task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic rst,
                         input logic [7:0] resp, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        opcode = op;
        funct3 = f3;
        rst_n  = rst;
        e.resp = resp;
        e.op   = op;
        e.f3   = f3;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle with a pending
    // expectation is a presented response.
    initial begin
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {w_mask, re, wb_sel, rwe};
                checks++;
                txn++;
                if (got !== e.resp) begin
                    failures++;
                    $display("FAIL txn=%0d %s op=%b f3=%b got=%b required=%b",
                             txn, e.name, e.op, e.f3, got, e.resp);
                end else begin
                    $display("ok   txn=%0d %s op=%b f3=%b out=%b", txn, e.name, e.op, e.f3, got);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        txn      = 0;
        rst_n    = 1'b0;
        opcode   = 7'b0000000;
        funct3   = 3'b000;

        // Reset state: bubble opcode under reset decodes to all zeros.
        apply(7'b0000000, 3'b000, 1'b0, 8'b0000_0_00_0, "reset_bubble");
        // Load under reset is decoded immediately.
        apply(7'b0000011, 3'b010, 1'b0, 8'b0000_1_00_1, "load_in_reset");

        // Stores
        apply(7'b0100011, 3'b000, 1'b1, 8'b0001_0_00_0, "store_sb");
        apply(7'b0100011, 3'b001, 1'b1, 8'b0011_0_00_0, "store_sh");
        apply(7'b0100011, 3'b010, 1'b1, 8'b1111_0_00_0, "store_sw");
        apply(7'b0100011, 3'b011, 1'b1, 8'b0000_0_00_0, "store_f3_011");
        // Loads
        apply(7'b0000011, 3'b000, 1'b1, 8'b0000_1_00_1, "load_lb");
        apply(7'b0000011, 3'b010, 1'b1, 8'b0000_1_00_1, "load_lw");
        apply(7'b0000011, 3'b100, 1'b1, 8'b0000_1_00_1, "load_lbu");
        apply(7'b0000011, 3'b101, 1'b1, 8'b0000_1_00_1, "load_lhu");
        // Jumps and ALU ops
        apply(7'b1101111, 3'b000, 1'b1, 8'b0000_0_10_1, "jal");
        apply(7'b1100111, 3'b000, 1'b1, 8'b0000_0_10_1, "jalr");
        apply(7'b0110111, 3'b011, 1'b1, 8'b0000_0_01_1, "lui");
        apply(7'b0010111, 3'b101, 1'b1, 8'b0000_0_01_1, "auipc");
        apply(7'b0110011, 3'b000, 1'b1, 8'b0000_0_01_1, "op");
        apply(7'b0010011, 3'b111, 1'b1, 8'b0000_0_01_1, "opimm");
        // Non-writing ops
        apply(7'b1100011, 3'b001, 1'b1, 8'b0000_0_00_0, "branch");
        apply(7'b1110011, 3'b001, 1'b1, 8'b0000_0_00_0, "csr");
        apply(7'b0000000, 3'b010, 1'b1, 8'b0000_0_00_0, "op_zero");
        apply(7'b1111111, 3'b010, 1'b1, 8'b0000_0_00_0, "op_ones");

        // Reset toggling with a steady store-word opcode
        apply(7'b0100011, 3'b010, 1'b1, 8'b1111_0_00_0, "rst_toggle_hi");
        apply(7'b0100011, 3'b010, 1'b0, 8'b1111_0_00_0, "rst_toggle_lo");
        apply(7'b0100011, 3'b010, 1'b1, 8'b1111_0_00_0, "rst_toggle_hi2");
        apply(7'b0000011, 3'b001, 1'b0, 8'b0000_1_00_1, "rst_toggle_load");

        // Full sweep
        for (int o = 0; o < 128; o++) begin
            for (int f = 0; f < 8; f++) begin
                apply(7'(o), 3'(f), 1'b1, model(7'(o), 3'(f)), "sweep");
            end
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
